// File: rtl/rs_pkg.sv
// Shared definitions for the reservation stations and the ROB.
package rs_pkg;

  // Instruction classes, shared with the ROB so both sides agree on routing.
  localparam logic [2:0] INST_ALU    = 3'd0;
  localparam logic [2:0] INST_MUL    = 3'd1;
  localparam logic [2:0] INST_LOAD   = 3'd2;
  localparam logic [2:0] INST_STORE  = 3'd3;
  localparam logic [2:0] INST_BRANCH = 3'd4;

endpackage

// File: rtl/rs_oldest_pick.sv
// Oldest-first picker: one-hot grant of the ready entry that no other ready entry is older than.
module rs_oldest_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0]        ready,
  input  logic [N-1:0][N-1:0] age,    // age[i][j] = 1 means entry i is older than entry j
  output logic [N-1:0]        grant
);

  logic [N-1:0] blocked;

  always_comb begin
    blocked = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j != i && ready[j] && age[j][i]) blocked[i] = 1'b1;
      end
    end
    grant = ready & ~blocked;
  end

endmodule

// File: rtl/rs_age_window.sv
// Age-ordered reservation station: captures operands from the CDB and issues the oldest ready entry.
module rs_age_window
  import rs_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [OP_W-1:0]            alloc_op,
  input  logic [TAG_W-1:0]           alloc_tag,
  input  logic                       alloc_s1_rdy,
  input  logic                       alloc_s2_rdy,
  input  logic [DATA_W-1:0]          alloc_s1_val,
  input  logic [DATA_W-1:0]          alloc_s2_val,
  input  logic [TAG_W-1:0]           alloc_s1_tag,
  input  logic [TAG_W-1:0]           alloc_s2_tag,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [OP_W-1:0]            iss_op,
  output logic [TAG_W-1:0]           iss_tag,
  output logic [DATA_W-1:0]          iss_s1,
  output logic [DATA_W-1:0]          iss_s2,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic              rdy;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } src_t;

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] tag;
    src_t             s1;
    src_t             s2;
  } rs_entry_t;

  // Handshake: a transfer happens on a cycle where valid && ready; valid never depends on ready.
  rs_entry_t                   ent_q [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0] age_q;
  logic [DEPTH-1:0]            valid_vec;
  logic [DEPTH-1:0]            ready_vec;
  logic [DEPTH-1:0]            grant;
  logic [IDX_W-1:0]            alloc_idx;
  logic                        alloc_fire;
  logic                        iss_fire;
  rs_entry_t                   alloc_ent;

  function automatic src_t capture_src(input logic rdy, input logic [TAG_W-1:0] tag,
                                       input logic [DATA_W-1:0] val);
    src_t s;
    s.tag = tag;
    s.rdy = rdy | (cdb_valid && tag == cdb_tag);
    s.val = rdy ? val : cdb_data;
    return s;
  endfunction

  always_comb begin
    occupancy = '0;
    alloc_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ent_q[i].valid;
      ready_vec[i] = ent_q[i].valid && ent_q[i].s1.rdy && ent_q[i].s2.rdy;
      occupancy    = occupancy + OCC_W'(ent_q[i].valid);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_vec[i]) alloc_idx = IDX_W'(i);
    end
  end

  assign alloc_ready = (occupancy != OCC_W'(DEPTH));
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;

  always_comb begin
    alloc_ent       = '0;
    alloc_ent.valid = 1'b1;
    alloc_ent.op    = alloc_op;
    alloc_ent.tag   = alloc_tag;
    alloc_ent.s1    = capture_src(alloc_s1_rdy, alloc_s1_tag, alloc_s1_val);
    alloc_ent.s2    = capture_src(alloc_s2_rdy, alloc_s2_tag, alloc_s2_val);
  end

  rs_oldest_pick #(.N(DEPTH)) u_pick (
    .ready (ready_vec),
    .age   (age_q),
    .grant (grant)
  );

  assign iss_valid = (|grant) && !flush;
  assign iss_fire  = iss_valid && iss_ready;

  always_comb begin
    iss_op  = '0;
    iss_tag = '0;
    iss_s1  = '0;
    iss_s2  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (iss_valid && grant[i]) begin
        iss_op  = ent_q[i].op;
        iss_tag = ent_q[i].tag;
        iss_s1  = ent_q[i].s1.val;
        iss_s2  = ent_q[i].s2.val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      age_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[i].valid && cdb_valid) begin
          if (!ent_q[i].s1.rdy && ent_q[i].s1.tag == cdb_tag) begin
            ent_q[i].s1.rdy <= 1'b1;
            ent_q[i].s1.val <= cdb_data;
          end
          if (!ent_q[i].s2.rdy && ent_q[i].s2.tag == cdb_tag) begin
            ent_q[i].s2.rdy <= 1'b1;
            ent_q[i].s2.val <= cdb_data;
          end
        end
        if (iss_fire && grant[i]) ent_q[i].valid <= 1'b0;
        if (alloc_fire && alloc_idx == IDX_W'(i)) ent_q[i] <= alloc_ent;
      end
      // New entry is younger than everything: clear its row, set its column.
      if (alloc_fire) begin
        for (int i = 0; i < DEPTH; i++) begin
          for (int j = 0; j < DEPTH; j++) begin
            if (alloc_idx == IDX_W'(i))      age_q[i][j] <= 1'b0;
            else if (alloc_idx == IDX_W'(j)) age_q[i][j] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_age_window.sv
// Directed bench for rs_age_window with an allocation-order queue model and an issue-order scoreboard.
module tb_rs_age_window;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int OP_W   = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              alloc_valid = 1'b0;
  logic              alloc_ready;
  logic [OP_W-1:0]   alloc_op = '0;
  logic [TAG_W-1:0]  alloc_tag = '0;
  logic              alloc_s1_rdy = 1'b0, alloc_s2_rdy = 1'b0;
  logic [DATA_W-1:0] alloc_s1_val = '0, alloc_s2_val = '0;
  logic [TAG_W-1:0]  alloc_s1_tag = '0, alloc_s2_tag = '0;
  logic              cdb_valid = 1'b0;
  logic [TAG_W-1:0]  cdb_tag = '0;
  logic [DATA_W-1:0] cdb_data = '0;
  logic              iss_valid;
  logic              iss_ready = 1'b0;
  logic [OP_W-1:0]   iss_op;
  logic [TAG_W-1:0]  iss_tag;
  logic [DATA_W-1:0] iss_s1, iss_s2;
  logic [3:0]        occupancy;

  int n_checks = 0;
  int n_pass   = 0;

  rs_age_window #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op), .alloc_tag(alloc_tag),
    .alloc_s1_rdy(alloc_s1_rdy), .alloc_s2_rdy(alloc_s2_rdy),
    .alloc_s1_val(alloc_s1_val), .alloc_s2_val(alloc_s2_val),
    .alloc_s1_tag(alloc_s1_tag), .alloc_s2_tag(alloc_s2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_tag(iss_tag),
    .iss_s1(iss_s1), .iss_s2(iss_s2), .occupancy(occupancy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: entries kept in allocation order, front is oldest.
  typedef struct {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag;
    logic              r1, r2;
    logic [TAG_W-1:0]  t1, t2;
    logic [DATA_W-1:0] v1, v2;
  } m_ent_t;

  m_ent_t            mq[$];
  logic [TAG_W-1:0]  exp_q[$];

  function automatic int model_sel();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].r1 && mq[i].r2) return i;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int     sel;
    bit     afire;
    m_ent_t e;
    if (rst) begin
      mq.delete();
    end else begin
      sel   = model_sel();
      afire = alloc_valid && (mq.size() < DEPTH) && !flush;
      if (flush) begin
        mq.delete();
      end else begin
        if (sel >= 0 && iss_ready) mq.delete(sel);
        if (cdb_valid) begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].r1 && mq[i].t1 == cdb_tag) begin mq[i].r1 = 1'b1; mq[i].v1 = cdb_data; end
            if (!mq[i].r2 && mq[i].t2 == cdb_tag) begin mq[i].r2 = 1'b1; mq[i].v2 = cdb_data; end
          end
        end
        if (afire) begin
          e.op = alloc_op; e.tag = alloc_tag;
          e.t1 = alloc_s1_tag; e.t2 = alloc_s2_tag;
          e.r1 = alloc_s1_rdy; e.v1 = alloc_s1_val;
          e.r2 = alloc_s2_rdy; e.v2 = alloc_s2_val;
          if (!e.r1 && cdb_valid && e.t1 == cdb_tag) begin e.r1 = 1'b1; e.v1 = cdb_data; end
          if (!e.r2 && cdb_valid && e.t2 == cdb_tag) begin e.r2 = 1'b1; e.v2 = cdb_data; end
          mq.push_back(e);
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    int sel;
    if (!rst) begin
      sel = model_sel();
      if (sel >= 0 && !flush) begin
        check("iss_valid", iss_valid, 1);
        check("iss_tag", iss_tag, mq[sel].tag);
        check("iss_op", iss_op, mq[sel].op);
        check("iss_s1", iss_s1, mq[sel].v1);
        check("iss_s2", iss_s2, mq[sel].v2);
      end else begin
        check("iss_valid_idle", iss_valid, 0);
        check("iss_zero", {iss_op, iss_tag, iss_s1, iss_s2}, 0);
      end
      check("occupancy", occupancy, mq.size());
      check("alloc_ready", alloc_ready, mq.size() < DEPTH);
      if (iss_valid && iss_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected_issue", iss_tag, 4'hx);
        else check("sb_issue_order", iss_tag, exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    alloc_valid = 1'b0;
    cdb_valid   = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic alloc(input logic [TAG_W-1:0] tag,
                       input logic r1, input logic [DATA_W-1:0] v1, input logic [TAG_W-1:0] t1,
                       input logic r2, input logic [DATA_W-1:0] v2, input logic [TAG_W-1:0] t2);
    alloc_valid  = 1'b1;
    alloc_tag    = tag;
    alloc_op     = 12'h100 + OP_W'(tag);
    alloc_s1_rdy = r1; alloc_s1_val = v1; alloc_s1_tag = t1;
    alloc_s2_rdy = r2; alloc_s2_val = v2; alloc_s2_tag = t2;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_iss_valid", iss_valid, 0);
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_occupancy", occupancy, 0);

    // Single allocation, both operands ready.
    alloc(4'd3, 1, 32'd5, 4'd0, 1, 32'd7, 4'd0);
    step();
    check("t1_iss_valid", iss_valid, 1);
    check("t1_iss_tag", iss_tag, 3);
    check("t1_iss_s1", iss_s1, 5);
    check("t1_iss_s2", iss_s2, 7);
    check("t1_occ", occupancy, 1);
    exp_q.push_back(4'd3);
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
    check("t1_occ_after", occupancy, 0);

    // Younger ready entry overtakes an older waiting one; CDB wakeup.
    alloc(4'd1, 0, 32'd0, 4'd9, 1, 32'd1, 4'd0);
    step();
    check("t2_wait_iss_valid", iss_valid, 0);
    alloc(4'd2, 1, 32'd2, 4'd0, 1, 32'd3, 4'd0);
    step();
    check("t2_first_tag", iss_tag, 2);
    exp_q.push_back(4'd2);
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
    cdb(4'd9, 32'h55);
    step();
    check("t2_wake_valid", iss_valid, 1);
    check("t2_wake_tag", iss_tag, 1);
    check("t2_wake_s1", iss_s1, 32'h55);
    exp_q.push_back(4'd1);
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;

    // Allocation bypass from the same-cycle CDB broadcast.
    alloc(4'd4, 1, 32'h11, 4'd0, 0, 32'd0, 4'd6);
    cdb(4'd6, 32'hAA);
    step();
    check("t3_bypass_valid", iss_valid, 1);
    check("t3_bypass_s2", iss_s2, 32'hAA);
    exp_q.push_back(4'd4);
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;

    // Both sources woken by one broadcast.
    alloc(4'd5, 0, 32'd0, 4'd7, 0, 32'd0, 4'd7);
    step();
    cdb(4'd7, 32'h3C);
    step();
    check("t3b_both_s1", iss_s1, 32'h3C);
    check("t3b_both_s2", iss_s2, 32'h3C);
    exp_q.push_back(4'd5);
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;

    // Fill to capacity, then drain in allocation order.
    for (int k = 0; k < DEPTH; k++) begin
      alloc(TAG_W'(k), 1, DATA_W'(k * 3), 4'd0, 1, DATA_W'(k + 100), 4'd0);
      step();
    end
    check("t4_full_ready", alloc_ready, 0);
    check("t4_full_occ", occupancy, 8);
    exp_q.push_back(4'd0);
    iss_ready = 1'b1;
    alloc(4'd15, 1, 32'hF0, 4'd0, 1, 32'hF1, 4'd0);
    step();
    check("t4_freed_ready", alloc_ready, 1);
    check("t4_freed_occ", occupancy, 7);
    exp_q.push_back(4'd1);
    alloc(4'd15, 1, 32'hF0, 4'd0, 1, 32'hF1, 4'd0);
    step();
    check("t4_swap_occ", occupancy, 7);
    for (int k = 2; k < DEPTH; k++) exp_q.push_back(TAG_W'(k));
    exp_q.push_back(4'd15);
    repeat (7) step();
    iss_ready = 1'b0;
    check("t4_drained_occ", occupancy, 0);

    // Flush overrides allocation and issue.
    for (int k = 10; k < 13; k++) begin
      alloc(TAG_W'(k), 1, DATA_W'(k), 4'd0, 1, DATA_W'(k), 4'd0);
      step();
    end
    check("t5_pre_occ", occupancy, 3);
    flush = 1'b1;
    iss_ready = 1'b1;
    alloc(4'd13, 1, 32'd1, 4'd0, 1, 32'd2, 4'd0);
    #1 check("t5_flush_iss_valid", iss_valid, 0);
    step();
    iss_ready = 1'b0;
    check("t5_occ", occupancy, 0);
    check("t5_alloc_ready", alloc_ready, 1);
    check("t5_iss_valid", iss_valid, 0);

    // Asynchronous reset between edges.
    for (int k = 1; k < 5; k++) begin
      alloc(TAG_W'(k), 1, DATA_W'(k), 4'd0, 1, DATA_W'(k), 4'd0);
      step();
    end
    check("t6_pre_occ", occupancy, 4);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_iss_valid", iss_valid, 0);
    check("t6_rst_occ", occupancy, 0);
    check("t6_rst_alloc_ready", alloc_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    check("t6_post_occ", occupancy, 0);

    check("sb_leftover", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rs_age_window.md
# rs_age_window

Parametrised, age-ordered reservation station for the out-of-order MIPS core. It sits between decode/rename (fed by register status and ROB lookups) and a single functional unit. It holds up to DEPTH waiting instructions and captures operands from the CDB. It issues the oldest ready entry over a valid/ready handshake. It adds a configurable depth, tag and data width, oldest-first selection, FU back-pressure and an occupancy count.

## Interface
Parameters:
- DEPTH, 8, number of entries (power of two, ≥2)
- DATA_W, 32, operand width
- TAG_W, 4, ROB tag width
- OP_W, 12, opaque op field ({opcode, funct})

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  mispredict flush; clears all entries
- alloc_valid  in  1  new instruction offered
- alloc_ready  out  1  at least one free entry
- alloc_op  in  OP_W  op field
- alloc_tag  in  TAG_W  destination ROB tag
- alloc_s1_rdy, alloc_s2_rdy  in  1  operand value already known
- alloc_s1_val, alloc_s2_val  in  DATA_W  operand value (valid when rdy)
- alloc_s1_tag, alloc_s2_tag  in  TAG_W  producer ROB tag (used when !rdy)
- cdb_valid  in  1  CDB broadcast
- cdb_tag  in  TAG_W  producing ROB tag
- cdb_data  in  DATA_W  broadcast value
- iss_valid  out  1  an entry is ready to issue
- iss_ready  in  1  FU accepts this cycle
- iss_op  out  OP_W  op field of the selected entry
- iss_tag  out  TAG_W  ROB tag of the selected entry
- iss_s1, iss_s2  out  DATA_W  operand values of the selected entry
- occupancy  out  $clog2(DEPTH+1)  number of valid entries

## Operation
- Each entry holds: valid, op, dest tag, and per source {rdy, tag, value}.
- Allocation fires when alloc_valid && alloc_ready && !flush.
  - The target is the lowest-index free entry.
  - The new entry is marked younger than every currently valid entry.
- Allocation bypass: if cdb_valid in the same cycle and a source is !rdy with tag == cdb_tag, store it as rdy with cdb_data.
- Wakeup: on cdb_valid, every valid entry with a !rdy source whose tag matches captures cdb_data and sets rdy. Both sources can match the same broadcast.
- Ready: valid && s1.rdy && s2.rdy, evaluated on registered state. A source woken this cycle becomes issuable next cycle.
- Selection: iss_* reflect the oldest ready entry, tracked by a DEPTH×DEPTH age matrix.
  - iss_valid is 0 when no entry is ready or flush is high.
  - When iss_valid = 0, all iss_* outputs are 0.
- Issue: on iss_valid && iss_ready, the selected entry is freed at the clock edge.
- alloc_ready is computed from registered state only (occupancy < DEPTH). A slot freed by an issue this cycle is not offered until the next cycle.
- Simultaneous issue + allocation: the freed and new entries are distinct, and occupancy stays unchanged.
- Flush: all entries are invalidated at the edge, and flush overrides allocation, issue and wakeup that cycle.
- Reset mid-operation: all state clears immediately, without waiting for a clock edge.
- Tag width is compared exactly, with no wrap logic; ROB tag reuse is the ROB's responsibility.

## Timing
- Reset values: all entries invalid, alloc_ready=1, iss_valid=0, iss_* = 0, occupancy=0.
- Allocate-to-issue latency, operands ready at allocation: entry written at edge N, iss_valid at N+1 (combinational from state).
- CDB wakeup latency: broadcast in cycle N, entry issuable in cycle N+1.
- iss_* are combinational from registered state and are independent of iss_ready (no ready→valid path).
- Occupancy updates one cycle after the allocate/issue edge: +1 per allocation, −1 per issue, 0 after flush.

## Structure
- Package rs_pkg: rs_entry_t struct (parametrised via localparams or typedef in the module), source struct {rdy, tag, value}, inst-type constants shared with the ROB.
- Sub-module rs_oldest_pick: takes the ready vector and the age matrix, returns a one-hot grant (pure combinational, reusable by load/store queues).
- The free-slot finder is an inline lowest-index priority encoder.

## Test plan
- Reset then single allocation, both operands ready (s1=5, s2=7, tag=3) -> iss_valid next cycle with iss_s1=5, iss_s2=7, iss_tag=3; iss_ready=1 frees it, occupancy returns 0.
- Allocate tag 1 (waiting on tag 9), then tag 2 (ready) -> tag 2 issues first. CDB tag 9 data 0x55 -> tag 1 issuable the cycle after, with iss_s1=0x55.
- Allocation with s2 waiting on tag 6 while cdb_valid, tag 6, data 0xAA in the same cycle -> entry stored ready, issues next cycle with iss_s2=0xAA.
- Fill all DEPTH=8 entries with iss_ready=0 -> alloc_ready=0, occupancy=8. One issue -> alloc_ready=1 the following cycle. Issues proceed in allocation order.
- All entries ready, then flush asserted together with alloc_valid and iss_ready -> no issue that cycle, occupancy=0 and alloc_ready=1 next cycle.
- Assert rst between clock edges with 4 valid entries -> iss_valid and occupancy drop to 0 immediately, before any clock edge.
